uncached_bus_arbiter: RTL and testbench
=======================================

# uncached_bus_arbiter

Shares the single external uncached bus between the instruction-fetch port and the data port. Each port's cache-control stage raises a request for addresses with bit 31 set. This block grants one requester at a time with round-robin priority, latches its address and write data, and drives the bus strobe until acknowledgement. It then returns a one-cycle ready pulse with registered read data, or an error after a bus timeout.

## Interface
- TIMEOUT_CYCLES, 255: bus cycles to wait for `bus_ack_i` before aborting; 0 disables the timeout. Range 0..65535.
- clock_i  in  1  system clock; all state updates on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- i_req_i  in  1  instruction port request; held until `i_ready_o`
- i_adr_i  in  32  instruction address; stable while `i_req_i` is high
- i_ready_o  out  1  one-cycle completion pulse to instruction port
- i_err_o  out  1  qualifies `i_ready_o`: access timed out
- i_dat_o  out  32  read data; valid when `i_ready_o` is high
- d_req_i  in  1  data port request; held until `d_ready_o`
- d_we_i  in  1  data port write enable
- d_adr_i  in  32  data address
- d_dat_i  in  32  data write value
- d_ready_o, d_err_o  out  1 each  as for the instruction port
- d_dat_o  out  32  read data for data port
- bus_stb_o  out  1  bus cycle active
- bus_we_o  out  1  bus write
- bus_adr_o  out  32  latched bus address
- bus_dat_o  out  32  latched bus write data
- bus_dat_i  in  32  bus read data; sampled on `bus_ack_i`
- bus_ack_i  in  1  bus acknowledge; ignored unless `bus_stb_o` is high

## Operation
- States:
  - IDLE: no strobe.
  - BUS: `bus_stb_o`=1, waiting for ack.
  - RESP: ready pulse to the owner.
- IDLE, with any request sampled at the edge: pick the owner, latch the owner's address/data/we into the bus registers (`bus_we_o`=0 for the instruction port), clear the timeout counter, go to BUS.
- Arbitration:
  - One requester: that requester wins.
  - Both requesting: the port that was not the last owner wins.
  - `last_owner` resets to DATA, so the instruction port wins the first tie.
  - `last_owner` updates at grant.
- BUS, `bus_ack_i`=1: capture `bus_dat_i` into the response register, err=0, go to RESP.
- BUS, no ack, counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): response data=0, err=1, go to RESP. Otherwise counter+1, saturating, 16 bits wide.
- Ack and timeout in the same cycle: ack wins.
- RESP:
  - The owner's `x_ready_o`=1 for exactly one cycle. The owner's `x_dat_o` and `x_err_o` are valid.
  - The non-owner's ready stays 0.
  - Always go to IDLE next.
- Requester drops its req on the edge after it sees ready. A req still high in IDLE is a new access.
- Writes also complete through RESP. `x_dat_o` is don't-care for writes, but is driven from the response register.
- Reset (asynchronous, any state):
  - State → IDLE.
  - Cleared to 0: `bus_stb_o`, `bus_we_o`, `bus_adr_o`, `bus_dat_o`, all ready/err outputs, response data, timeout counter.
  - `last_owner`=DATA.
  - An in-flight bus cycle is abandoned with no response.

## Timing
- Request sampled in IDLE in cycle 0 → `bus_stb_o` high from cycle 1.
- Ack in cycle k (k≥1) → ready in cycle k+1 → IDLE in cycle k+2.
- Minimum request-to-ready latency: 2 cycles. Back-to-back grants: one access per 3 cycles minimum.
- With TIMEOUT_CYCLES=T: strobe is high for T cycles, then ready+err in cycle T+1.
- All outputs are decoded from registers. There is no combinational path from any input to any output.

## Structure
- Package `uncached_bus_pkg`:
  - State encoding: IDLE/BUS/RESP.
  - Owner encoding: OWNER_I=0, OWNER_D=1.
  - Timeout counter width constant (16).
- Sub-module `rr_pick2`: combinational two-way round-robin pick. Inputs: two requests and `last_owner`. Outputs: grant valid and winner.

## Test plan
- Single instruction read: `i_adr_i`=0x80000010, ack in cycle 3 with 0xDEADBEEF → bus_adr=0x80000010, we=0, strobe cycles 1–3, i_ready=1 in cycle 4 with i_dat=0xDEADBEEF, i_err=0.
- Data write: d_we=1, `d_adr_i`=0x80000020, `d_dat_i`=0x12345678, ack in cycle 1 → bus_we=1, bus_dat=0x12345678, d_ready in cycle 2, i_ready stays 0.
- Tie after reset: both requests held → instruction granted first, then data, then instruction. `last_owner` alternates.
- Timeout with TIMEOUT_CYCLES=4, ack never asserted → strobe high cycles 1–4, d_ready=1 and d_err=1 with d_dat=0 in cycle 5. Ack in cycle 4 instead → normal completion, err=0.
- Reset asserted in BUS → strobe and all outputs 0 immediately, before the clock edge. After release, a fresh request gets normal 2-cycle minimum latency.
- Spurious `bus_ack_i` in IDLE/RESP → ignored: no ready pulse, no state change.

Source files
------------

// File: rtl/uncached_bus_pkg.sv
// Purpose: shared types and constants for the uncached bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, bus-owner encoding, the timeout counter
// width, the latched bus-request record and a saturating increment helper.

package uncached_bus_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no strobe, waiting for a request
        BUS  = 2'd1,   // strobe high, waiting for ack or timeout
        RESP = 2'd2    // one-cycle ready pulse to the owner
    } state_t;

    // Which port currently owns (or last owned) the bus.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    // Timeout counter width; TIMEOUT_CYCLES must fit in it.
    localparam int TMO_CNT_W = 16;
    typedef logic [TMO_CNT_W-1:0] tmo_cnt_t;

    // Bus cycle attributes latched at grant time.
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_req_t;

    // Saturating increment: the counter parks at all-ones rather than
    // wrapping, so a disabled timeout never aliases back to a small value.
    function automatic tmo_cnt_t tmo_inc(input tmo_cnt_t cnt);
        tmo_cnt_t nxt;
        nxt = (cnt == '1) ? cnt : cnt + 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/uncached_bus_arbiter_rr_pick2.sv
// Purpose: two-way round-robin pick between the instruction and data ports.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   i_req      instruction port request
//   d_req      data port request
//   last_owner port granted most recently
//   gnt_vld    at least one request is present
//   winner     selected port (valid when gnt_vld is high)

module rr_pick2
    import uncached_bus_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   gnt_vld,
    output owner_t winner
);

    always_comb begin
        gnt_vld = i_req | d_req;
        winner  = OWNER_I;
        if (i_req && d_req) begin
            // Tie: the port that did not win last time goes first.
            winner = (last_owner == OWNER_D) ? OWNER_I : OWNER_D;
        end else if (d_req) begin
            winner = OWNER_D;
        end
    end

endmodule

// File: rtl/uncached_bus_arbiter.sv
// Purpose: shares one uncached external bus between instruction and data ports.
// Latency: request-to-ready 2 cycles minimum (grant, ack, ready); one access per 3 cycles.
// Backpressure: requesters hold req until their ready pulse; the bus stalls via bus_ack_i, bounded by a timeout.
//
// Ports:
//   clock_i, reset_n_i            clock and asynchronous active-low reset
//   i_req_i / i_adr_i             instruction port request and address
//   i_ready_o / i_err_o / i_dat_o instruction completion pulse, error flag, read data
//   d_req_i / d_we_i / d_adr_i / d_dat_i  data port request, write enable, address, write data
//   d_ready_o / d_err_o / d_dat_o data completion pulse, error flag, read data
//   bus_stb_o / bus_we_o / bus_adr_o / bus_dat_o  external bus cycle, all registered
//   bus_dat_i / bus_ack_i         external bus read data and acknowledge
//
// Every output is decoded from flops; no input reaches an output
// combinationally. TIMEOUT_CYCLES = 0 disables the timeout.

module uncached_bus_arbiter
    import uncached_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock_i,
    input  logic        reset_n_i,

    input  logic        i_req_i,
    input  logic [31:0] i_adr_i,
    output logic        i_ready_o,
    output logic        i_err_o,
    output logic [31:0] i_dat_o,

    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_adr_i,
    input  logic [31:0] d_dat_i,
    output logic        d_ready_o,
    output logic        d_err_o,
    output logic [31:0] d_dat_o,

    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i
);

    // The timeout fires when the counter reaches TIMEOUT_CYCLES-1, which with
    // the counter cleared at grant gives exactly TIMEOUT_CYCLES strobe cycles.
    localparam bit       TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam tmo_cnt_t TMO_LAST = tmo_cnt_t'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,      state_d;
    owner_t      owner_q,      owner_d;
    owner_t      last_owner_q, last_owner_d;
    bus_req_t    bus_q,        bus_d;
    tmo_cnt_t    cnt_q,        cnt_d;
    logic [31:0] rsp_dat_q,    rsp_dat_d;
    logic        rsp_err_q,    rsp_err_d;

    logic        gnt_vld;
    owner_t      winner;

    // ------------------------------------------------------------------
    // Round-robin pick
    // ------------------------------------------------------------------
    rr_pick2 u_pick (
        .i_req      (i_req_i),
        .d_req      (d_req_i),
        .last_owner (last_owner_q),
        .gnt_vld    (gnt_vld),
        .winner     (winner)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers (owner, bus latches, timeout counter, response)
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            owner_q      <= OWNER_D;
            last_owner_q <= OWNER_D;
            bus_q        <= '0;
            cnt_q        <= '0;
            rsp_dat_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            bus_q        <= bus_d;
            cnt_q        <= cnt_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        bus_d        = bus_q;
        cnt_d        = cnt_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d      = winner;
                    last_owner_d = winner;
                    cnt_d        = '0;
                    state_d      = BUS;
                    if (winner == OWNER_D) begin
                        bus_d.we  = d_we_i;
                        bus_d.adr = d_adr_i;
                        bus_d.dat = d_dat_i;
                    end else begin
                        // Instruction fetches are always reads with no payload.
                        bus_d.we  = 1'b0;
                        bus_d.adr = i_adr_i;
                        bus_d.dat = '0;
                    end
                end
            end

            BUS: begin
                // Ack has priority over a timeout landing in the same cycle.
                if (bus_ack_i) begin
                    rsp_dat_d = bus_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = tmo_inc(cnt_q);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from flops
    // ------------------------------------------------------------------
    assign bus_stb_o = (state_q == BUS);
    assign bus_we_o  = bus_q.we;
    assign bus_adr_o = bus_q.adr;
    assign bus_dat_o = bus_q.dat;

    assign i_ready_o = (state_q == RESP) && (owner_q == OWNER_I);
    assign d_ready_o = (state_q == RESP) && (owner_q == OWNER_D);

    // Error is only meaningful alongside ready, so it is gated to keep the
    // non-owner's flag quiet.
    assign i_err_o   = i_ready_o & rsp_err_q;
    assign d_err_o   = d_ready_o & rsp_err_q;

    assign i_dat_o   = rsp_dat_q;
    assign d_dat_o   = rsp_dat_q;

endmodule

// File: tb/tb_uncached_bus_arbiter.sv
// Purpose: self-checking bench for uncached_bus_arbiter (directed + randomized scoreboard).
// Latency: n/a.
// Backpressure: n/a.

module tb_uncached_bus_arbiter;

    localparam int unsigned T = 4;

    logic        clock_i   = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        i_req_i   = 1'b0;
    logic [31:0] i_adr_i   = '0;
    logic        i_ready_o, i_err_o;
    logic [31:0] i_dat_o;
    logic        d_req_i   = 1'b0;
    logic        d_we_i    = 1'b0;
    logic [31:0] d_adr_i   = '0;
    logic [31:0] d_dat_i   = '0;
    logic        d_ready_o, d_err_o;
    logic [31:0] d_dat_o;
    logic        bus_stb_o, bus_we_o;
    logic [31:0] bus_adr_o, bus_dat_o;
    logic [31:0] bus_dat_i = '0;
    logic        bus_ack_i = 1'b0;

    always #5 clock_i = ~clock_i;

    uncached_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .i_req_i   (i_req_i),
        .i_adr_i   (i_adr_i),
        .i_ready_o (i_ready_o),
        .i_err_o   (i_err_o),
        .i_dat_o   (i_dat_o),
        .d_req_i   (d_req_i),
        .d_we_i    (d_we_i),
        .d_adr_i   (d_adr_i),
        .d_dat_i   (d_dat_i),
        .d_ready_o (d_ready_o),
        .d_err_o   (d_err_o),
        .d_dat_o   (d_dat_o),
        .bus_stb_o (bus_stb_o),
        .bus_we_o  (bus_we_o),
        .bus_adr_o (bus_adr_o),
        .bus_dat_o (bus_dat_o),
        .bus_dat_i (bus_dat_i),
        .bus_ack_i (bus_ack_i)
    );

    int checks   = 0;
    int failures = 0;

    // Expected response of one bus access: strobe length, data, error.
    typedef struct {
        int          len;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t exp_q[$];   // pushed by the bus responder when it picks the ack delay
    int   port_q[$];  // pushed at grant: bit0 = port (1 = data), bit1 = write
    bit   mon_en = 1'b0;
    int   m_last = 1; // model of the last granted port; data after reset

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, predicts grants from the
    // round-robin rule and pops the scoreboard on every ready pulse.
    // ------------------------------------------------------------------
    initial begin
        logic prev_stb;
        logic prev_i;
        logic prev_d;
        int   stb_len;
        int   w;
        int   code;
        exp_t e;
        prev_stb = 1'b0;
        prev_i   = 1'b0;
        prev_d   = 1'b0;
        stb_len  = 0;
        forever begin
            @(negedge clock_i);
            if (mon_en) begin
                if (bus_stb_o && !prev_stb) begin
                    chk("grant_had_request", 32'(prev_i | prev_d), 32'd1);
                    if (prev_i && prev_d) w = (m_last == 1) ? 0 : 1;
                    else if (prev_d)      w = 1;
                    else                  w = 0;
                    m_last = w;
                    if (w == 0) begin
                        chk("grant_i_adr", bus_adr_o, i_adr_i);
                        chk("grant_i_we", 32'(bus_we_o), 32'd0);
                        code = 0;
                    end else begin
                        chk("grant_d_adr", bus_adr_o, d_adr_i);
                        chk("grant_d_we", 32'(bus_we_o), 32'(d_we_i));
                        if (d_we_i) chk("grant_d_wdat", bus_dat_o, d_dat_i);
                        code = d_we_i ? 3 : 1;
                    end
                    port_q.push_back(code);
                    stb_len = 1;
                end else if (bus_stb_o) begin
                    stb_len++;
                end

                if (i_ready_o || d_ready_o) begin
                    chk("single_ready", 32'(i_ready_o & d_ready_o), 32'd0);
                    if (exp_q.size() == 0 || port_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ready: got i_ready=%0b d_ready=%0b expected none at %0t",
                                 i_ready_o, d_ready_o, $time);
                    end else begin
                        e    = exp_q.pop_front();
                        code = port_q.pop_front();
                        chk("ready_port", 32'(d_ready_o), 32'(code & 1));
                        chk("strobe_len", 32'(stb_len), 32'(e.len));
                        if ((code & 1) == 1) begin
                            chk("d_err", 32'(d_err_o), 32'(e.err));
                            chk("i_err_quiet", 32'(i_err_o), 32'd0);
                            if (((code >> 1) == 0) || e.err) chk("d_dat", d_dat_o, e.dat);
                        end else begin
                            chk("i_err", 32'(i_err_o), 32'(e.err));
                            chk("d_err_quiet", 32'(d_err_o), 32'd0);
                            chk("i_dat", i_dat_o, e.dat);
                        end
                    end
                end
            end
            prev_stb = bus_stb_o;
            prev_i   = i_req_i;
            prev_d   = d_req_i;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequences, then randomized requesters and bus responder.
    // ------------------------------------------------------------------
    initial begin
        bit          active;
        int          n;
        int          ack_at;
        logic [31:0] rdat;
        bit          gen_en;
        exp_t        e;
        active = 1'b0;
        n      = 0;
        ack_at = 0;
        rdat   = '0;

        // Reset state.
        step();
        step();
        chk("reset_ctrl", 32'({bus_stb_o, bus_we_o, i_ready_o, i_err_o, d_ready_o, d_err_o}), 32'd0);
        chk("reset_bus_adr", bus_adr_o, 32'd0);
        chk("reset_bus_dat", bus_dat_o, 32'd0);
        chk("reset_rsp_dat", i_dat_o | d_dat_o, 32'd0);
        reset_n_i = 1'b1;

        // Single instruction read, ack in cycle 3.
        step();
        i_req_i = 1'b1;
        i_adr_i = 32'h8000_0010;
        step();
        chk("ifetch_stb_c1", 32'(bus_stb_o), 32'd1);
        chk("ifetch_adr", bus_adr_o, 32'h8000_0010);
        chk("ifetch_we", 32'(bus_we_o), 32'd0);
        step();
        step();
        chk("ifetch_stb_c3", 32'(bus_stb_o), 32'd1);
        bus_ack_i = 1'b1;
        bus_dat_i = 32'hDEAD_BEEF;
        step();
        bus_ack_i = 1'b0;
        chk("ifetch_ready", 32'(i_ready_o), 32'd1);
        chk("ifetch_dat", i_dat_o, 32'hDEAD_BEEF);
        chk("ifetch_err", 32'(i_err_o), 32'd0);
        chk("ifetch_d_ready", 32'(d_ready_o), 32'd0);
        chk("ifetch_stb_c4", 32'(bus_stb_o), 32'd0);
        i_req_i = 1'b0;
        step();
        chk("ifetch_ready_once", 32'(i_ready_o), 32'd0);

        // Data write, then reset while the strobe is high.
        d_req_i = 1'b1;
        d_we_i  = 1'b1;
        d_adr_i = 32'h8000_0020;
        d_dat_i = 32'h1234_5678;
        step();
        chk("dwr_stb", 32'(bus_stb_o), 32'd1);
        chk("dwr_we", 32'(bus_we_o), 32'd1);
        chk("dwr_dat", bus_dat_o, 32'h1234_5678);
        chk("dwr_adr", bus_adr_o, 32'h8000_0020);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("async_reset_ctrl", 32'({bus_stb_o, bus_we_o, d_ready_o, i_ready_o}), 32'd0);
        chk("async_reset_bus", bus_adr_o | bus_dat_o, 32'd0);
        d_req_i = 1'b0;
        step();
        step();
        reset_n_i = 1'b1;

        // Fresh data write after reset: minimum latency, ack in cycle 1.
        step();
        d_req_i = 1'b1;
        step();
        chk("post_reset_stb", 32'(bus_stb_o), 32'd1);
        bus_ack_i = 1'b1;
        bus_dat_i = 32'hCAFE_0001;
        step();
        bus_ack_i = 1'b0;
        chk("post_reset_d_ready", 32'(d_ready_o), 32'd1);
        chk("post_reset_d_err", 32'(d_err_o), 32'd0);
        chk("post_reset_i_ready", 32'(i_ready_o), 32'd0);
        d_req_i = 1'b0;
        step();

        // Spurious ack while idle.
        for (int k = 0; k < 3; k++) begin
            bus_ack_i = 1'b1;
            step();
            chk("spurious_ack", 32'({bus_stb_o, i_ready_o, d_ready_o}), 32'd0);
        end
        bus_ack_i = 1'b0;

        // Randomized phase; last grant above went to the data port.
        m_last = 1;
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 2600; cyc++) begin
            step();
            gen_en = (cyc < 2500);

            if (i_req_i) begin
                if (i_ready_o) i_req_i = 1'b0;
            end else if (gen_en && $urandom_range(0, 99) < 55) begin
                i_adr_i = {1'b1, 31'($urandom)};
                i_req_i = 1'b1;
            end

            if (d_req_i) begin
                if (d_ready_o) d_req_i = 1'b0;
            end else if (gen_en && $urandom_range(0, 99) < 55) begin
                d_adr_i = {1'b1, 31'($urandom)};
                d_we_i  = 1'($urandom_range(0, 1));
                d_dat_i = $urandom;
                d_req_i = 1'b1;
            end

            if (bus_stb_o) begin
                if (!active) begin
                    active = 1'b1;
                    n      = 1;
                    ack_at = $urandom_range(1, 7);
                    rdat   = $urandom;
                    if (ack_at <= int'(T)) begin
                        e.len = ack_at;
                        e.dat = rdat;
                        e.err = 1'b0;
                    end else begin
                        e.len = int'(T);
                        e.dat = 32'd0;
                        e.err = 1'b1;
                    end
                    exp_q.push_back(e);
                end else begin
                    n++;
                end
                bus_ack_i = (n == ack_at);
                bus_dat_i = bus_ack_i ? rdat : $urandom;
            end else begin
                active    = 1'b0;
                bus_ack_i = ($urandom_range(0, 3) == 0);
                bus_dat_i = $urandom;
            end
        end

        bus_ack_i = 1'b0;
        step();
        chk("drain_i_served", 32'(i_req_i), 32'd0);
        chk("drain_d_served", 32'(d_req_i), 32'd0);
        chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_port_empty", 32'(port_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
